// File: rtl/arm_control_unit.sv
// arm_control_unit: control unit for the single-cycle ARM calculator datapath.
// Decodes the instruction into datapath strobes, holds the NZCV register,
// evaluates condition codes and sequences HOLD -> RUN -> HALT.
// Optional build macro CTRL_RETIRE_CNT_EN adds the RetireCount output.
module arm_control_unit #(
  parameter int HOLD_CYCLES = 1,
  parameter int CNT_WIDTH   = 32
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCSrc,
  output logic        MemtoReg,
  output logic        MemWrite,
  output logic [1:0]  ALUControl,
  output logic [1:0]  ALUSrc,
  output logic [1:0]  ImmSrc,
  output logic        RegWrite,
  output logic [1:0]  RegSrc,
  output logic [3:0]  Flags,
  output logic        Halted
`ifdef CTRL_RETIRE_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] RetireCount
`endif
);

  typedef enum logic [1:0] {
    S_HOLD = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  localparam logic [3:0] HOLD_INIT = 4'(HOLD_CYCLES - 1);

  state_t      state, state_nxt;
  logic [3:0]  hold_cnt, hold_cnt_nxt;
  logic [3:0]  flags_q;

  logic [1:0]  op;
  logic [5:0]  funct;
  logic [3:0]  cmd;
  logic        s_bit;
  logic [3:0]  rd;

  logic        regw, memw, branch, undef;
  logic [1:0]  flag_w;
  logic        cond_ex;
  logic        wr_en;
  logic        pcs;

  // Rn and the low operand field are datapath-only; the control unit ignores them.
  logic        unused_instr;
  assign unused_instr = ^{Instr[19:16], Instr[11:0]};

  assign op    = Instr[27:26];
  assign funct = Instr[25:20];
  assign cmd   = funct[4:1];
  assign s_bit = funct[0];
  assign rd    = Instr[15:12];

  // Main and ALU decode; an undefined encoding clears every decoded field.
  always_comb begin
    regw       = 1'b0;
    memw       = 1'b0;
    branch     = 1'b0;
    undef      = 1'b0;
    flag_w     = 2'b00;
    MemtoReg   = 1'b0;
    ALUControl = 2'b00;
    ALUSrc     = 2'b00;
    ImmSrc     = 2'b00;
    RegSrc     = 2'b00;
    case (op)
      2'b00: begin
        regw   = 1'b1;
        ALUSrc = funct[5] ? 2'b01 : 2'b00;
        case (cmd)
          4'b0100: begin ALUControl = 2'b00; flag_w = {s_bit, s_bit}; end
          4'b0010: begin ALUControl = 2'b01; flag_w = {s_bit, s_bit}; end
          4'b0000: begin ALUControl = 2'b10; flag_w = {s_bit, 1'b0}; end
          4'b1100: begin ALUControl = 2'b11; flag_w = {s_bit, 1'b0}; end
          4'b1010: begin
            // CMP only exists as a flag-setting compare.
            ALUControl = 2'b01;
            regw       = 1'b0;
            flag_w     = {s_bit, s_bit};
            undef      = ~s_bit;
          end
          default: undef = 1'b1;
        endcase
      end
      2'b01: begin
        ALUSrc     = 2'b01;
        ImmSrc     = 2'b01;
        ALUControl = funct[3] ? 2'b00 : 2'b01;
        if (funct[0]) begin
          regw     = 1'b1;
          MemtoReg = 1'b1;
        end else begin
          memw   = 1'b1;
          RegSrc = 2'b10;
        end
      end
      2'b10: begin
        branch = 1'b1;
        ALUSrc = 2'b01;
        ImmSrc = 2'b10;
        RegSrc = 2'b01;
      end
      default: undef = 1'b1;
    endcase
    if (undef) begin
      regw       = 1'b0;
      memw       = 1'b0;
      branch     = 1'b0;
      flag_w     = 2'b00;
      MemtoReg   = 1'b0;
      ALUControl = 2'b00;
      ALUSrc     = 2'b00;
      ImmSrc     = 2'b00;
      RegSrc     = 2'b00;
    end
  end

  // Condition check against the registered flags only.
  always_comb begin
    cond_ex = 1'b0;
    case (Instr[31:28])
      4'h0: cond_ex = flags_q[2];
      4'h1: cond_ex = ~flags_q[2];
      4'h2: cond_ex = flags_q[1];
      4'h3: cond_ex = ~flags_q[1];
      4'h4: cond_ex = flags_q[3];
      4'h5: cond_ex = ~flags_q[3];
      4'h6: cond_ex = flags_q[0];
      4'h7: cond_ex = ~flags_q[0];
      4'h8: cond_ex = flags_q[1] & ~flags_q[2];
      4'h9: cond_ex = ~flags_q[1] | flags_q[2];
      4'hA: cond_ex = (flags_q[3] == flags_q[0]);
      4'hB: cond_ex = (flags_q[3] != flags_q[0]);
      4'hC: cond_ex = ~flags_q[2] & (flags_q[3] == flags_q[0]);
      4'hD: cond_ex = flags_q[2] | (flags_q[3] != flags_q[0]);
      4'hE: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // Strobes only fire in RUN and never while reset is held low.
  assign wr_en    = (state == S_RUN) & RST_N;
  assign pcs      = branch | (regw & (rd == 4'hF));
  assign PCSrc    = pcs  & cond_ex & wr_en;
  assign RegWrite = regw & cond_ex & wr_en;
  assign MemWrite = memw & cond_ex & wr_en;
  assign Halted   = (state == S_HALT) & RST_N;
  assign Flags    = flags_q;

  // NZCV register: NZ and CV halves update independently.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      flags_q <= 4'b0000;
    end else begin
      if (flag_w[1] & cond_ex & wr_en) flags_q[3:2] <= ALUFlags[3:2];
      if (flag_w[0] & cond_ex & wr_en) flags_q[1:0] <= ALUFlags[1:0];
    end
  end

  // State and hold-counter registers.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state    <= S_HOLD;
      hold_cnt <= HOLD_INIT;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_cnt_nxt;
    end
  end

  // Next state: settle in HOLD, trap executed undefined instructions into HALT.
  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    case (state)
      S_HOLD: begin
        if (hold_cnt == 4'd0) state_nxt = S_RUN;
        else                  hold_cnt_nxt = hold_cnt - 4'd1;
      end
      S_RUN: begin
        if (undef & cond_ex) state_nxt = S_HALT;
      end
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_HOLD;
    endcase
  end

`ifdef CTRL_RETIRE_CNT_EN
  logic [CNT_WIDTH-1:0] retire_q;

  // Count executed, defined instructions; wraps naturally.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      retire_q <= '0;
    end else if ((state == S_RUN) & cond_ex & ~undef) begin
      retire_q <= retire_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign RetireCount = retire_q;
`else
  localparam int unused_cnt_w = CNT_WIDTH;
`endif

endmodule
